// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR/decimator width defaults and helpers
//
// Purpose: default sample widths, requantisation shift, output FIFO depth
//          and the accumulator width shared by the FIR filter and decimator.
// Ports:   none (package).
package fir_pkg;

  localparam int DIN_W       = 10;  // signed FIR-output sample width
  localparam int DOUT_W      = 8;   // signed decimated sample width
  localparam int SHIFT       = 2;   // post-average requantisation shift (>= 1)
  localparam int FIFO_DEPTH  = 4;   // output FIFO entries, power of two (>= 2)
  localparam int MAX_DEC_SEL = 3;   // largest decimation exponent (N = 8)
  localparam int CNT_W       = 3;   // sample counter width, holds 0..7
  localparam int ACC_W       = DIN_W + MAX_DEC_SEL;

  // Counter value at which a frame of 2^sel samples closes.
  function automatic logic [CNT_W-1:0] frame_last(input logic [1:0] sel);
    return CNT_W'((1 << sel) - 1);
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - show-ahead synchronous FIFO for decimated samples
//
// Purpose: stores decimated results; the oldest entry is always visible on
//          head. A push into a full FIFO succeeds only when a pop happens in
//          the same cycle. Pops while empty are ignored and head keeps the
//          last value that was popped.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   push       write push_data this cycle
//   push_data  entry to store
//   pop        consumer takes head this cycle (ignored when empty)
//   head       oldest entry (last popped value while empty)
//   level      occupancy 0..DEPTH
//   full       level == DEPTH
//   empty      level == 0
module fir_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [W-1:0]  last_q;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign level = count;
  assign head  = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - averaging decimator with requantisation and output FIFO
//
// Purpose: averages frames of N = 2^dec_sel accepted FIR samples, rounds
//          half-up with an arithmetic shift of dec_sel+SHIFT, saturates to
//          DOUT_W bits, registers the result one stage and buffers it in a
//          show-ahead FIFO. The result of a frame becomes visible on dout two
//          cycles after its closing sample is presented.
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   din         signed input sample
//   din_valid   din qualifier, one sample per cycle
//   dec_sel     decimation exponent, N = 2^dec_sel
//   dout        signed decimated sample (FIFO head)
//   dout_valid  FIFO non-empty
//   dout_ready  consumer accept
//   overflow    sticky: a result was saturated
//   drop        one-cycle pulse: a result was lost to a full FIFO
//   fifo_level  FIFO occupancy
module fir_decimator #(
  parameter int DIN_W      = fir_pkg::DIN_W,
  parameter int DOUT_W     = fir_pkg::DOUT_W,
  parameter int SHIFT      = fir_pkg::SHIFT,
  parameter int FIFO_DEPTH = fir_pkg::FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DIN_W-1:0]       din,
  input  logic                          din_valid,
  input  logic [1:0]                    dec_sel,
  output logic signed [DOUT_W-1:0]      dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          overflow,
  output logic                          drop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  import fir_pkg::*;

  localparam int ACC_BITS = DIN_W + MAX_DEC_SEL;
  // One extra bit so adding the rounding constant to a full-scale sum cannot wrap.
  localparam int SUM_W    = ACC_BITS + 1;
  localparam logic signed [SUM_W-1:0] OUT_MAX = SUM_W'((1 <<< (DOUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] OUT_MIN = SUM_W'(-(1 <<< (DOUT_W - 1)));

  logic signed [ACC_BITS-1:0] acc;
  logic [CNT_W-1:0]           cnt;
  logic [1:0]                 sel_q;
  logic [DOUT_W-1:0]          res_q;
  logic                       res_vld;

  logic [1:0]                 sel_eff;
  logic                       frame_end;
  logic signed [ACC_BITS-1:0] din_ext;
  logic signed [SUM_W-1:0]    sum;
  logic signed [SUM_W-1:0]    bias;
  logic signed [SUM_W-1:0]    rounded;
  logic signed [SUM_W-1:0]    shifted;
  logic                       sat_hi;
  logic                       sat_lo;
  logic [DOUT_W-1:0]          result;
  logic                       fifo_full;
  logic                       fifo_empty;
  int                         shamt;

  // The first sample of a frame uses the live dec_sel (it is being latched on
  // that same edge); later samples use the latched copy so a mid-frame change
  // only affects the next frame.
  assign sel_eff   = (cnt == '0) ? dec_sel : sel_q;
  assign frame_end = (cnt == frame_last(sel_eff));
  assign din_ext   = {{(ACC_BITS - DIN_W){din[DIN_W-1]}}, din};

  always_comb begin
    shamt   = int'(sel_eff) + SHIFT;
    sum     = {acc[ACC_BITS-1], acc} + {din_ext[ACC_BITS-1], din_ext};
    bias    = SUM_W'(1) <<< (shamt - 1);
    rounded = sum + bias;
    shifted = rounded >>> shamt;
    sat_hi  = (shifted > OUT_MAX);
    sat_lo  = (shifted < OUT_MIN);
    result  = shifted[DOUT_W-1:0];
    if (sat_hi) begin
      result = OUT_MAX[DOUT_W-1:0];
    end else if (sat_lo) begin
      result = OUT_MIN[DOUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      cnt      <= '0;
      sel_q    <= '0;
      res_q    <= '0;
      res_vld  <= 1'b0;
      overflow <= 1'b0;
      drop     <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      // The pipeline result is lost only if the FIFO is full and nothing leaves.
      drop    <= res_vld && fifo_full && !(dout_valid && dout_ready);
      if (din_valid) begin
        if (cnt == '0) begin
          sel_q <= dec_sel;
        end
        if (frame_end) begin
          acc     <= '0;
          cnt     <= '0;
          res_q   <= result;
          res_vld <= 1'b1;
          if (sat_hi || sat_lo) begin
            overflow <= 1'b1;
          end
        end else begin
          acc <= acc + din_ext;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  fir_sync_fifo #(
    .W     (DOUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_vld),
    .push_data (res_q),
    .pop       (dout_ready),
    .head      (dout),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign dout_valid = !fifo_empty;

endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 Parameter DIN_W, 10, signed FIR-output sample width.
REQ-002 Parameter DOUT_W, 8, signed output sample width.
REQ-003 Parameter SHIFT, 2, fixed requantisation right-shift applied after averaging.
REQ-004 Parameter FIFO_DEPTH, 4, output FIFO entries (power of two).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 din  in  DIN_W  signed sample from the upstream FIR filter.
REQ-008 din_valid  in  1  din qualifier; one sample accepted per cycle when high.
REQ-009 dec_sel  in  2  decimation factor N = 2^dec_sel (1, 2, 4, 8).
REQ-010 dout  out  DOUT_W  signed decimated sample, FIFO head.
REQ-011 dout_valid  out  1  FIFO non-empty.
REQ-012 dout_ready  in  1  consumer accept; pop when dout_valid && dout_ready.
REQ-013 overflow  out  1  sticky flag: a result was saturated.
REQ-014 drop  out  1  one-cycle pulse: a result was discarded because the FIFO was full.
REQ-015 fifo_level  out  3  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-016 Accumulator SHALL be DIN_W+3 bits signed; sign-extend din; no wrap for any legal input and any N.
REQ-017 Sample counter SHALL count accepted samples 0..N-1; on count N-1, sum = acc + din, acc and counter clear the same cycle.
REQ-018 dec_sel SHALL be latched only when the counter is 0 and a sample is accepted; mid-frame changes take effect from the next frame.
REQ-019 Result SHALL be (sum + 2^(dec_sel+SHIFT-1)) >>> (dec_sel+SHIFT), i.e. round-half-up, arithmetic shift.
REQ-020 Result SHALL saturate to [-2^(DOUT_W-1), 2^(DOUT_W-1)-1]; any saturation sets overflow until reset.
REQ-021 Rounded/saturated result SHALL be registered one stage, then pushed to the FIFO; dout_valid rises 2 cycles after the frame-closing sample edge with an empty FIFO.
REQ-022 FIFO SHALL be show-ahead: dout shows the oldest entry whenever dout_valid=1; order preserved.
REQ-023 Push when full SHALL succeed if a pop occurs the same cycle; otherwise result discarded, drop pulses, FIFO unchanged.
REQ-024 Simultaneous push and pop with 0 < level < FIFO_DEPTH SHALL leave fifo_level unchanged.
REQ-025 Pop when empty SHALL be ignored; dout holds its last value.
REQ-026 din_valid=0 cycles SHALL not advance the counter or alter acc.

Reset
REQ-027 rst low SHALL immediately clear acc, counter, latched dec_sel, pipeline register, FIFO pointers, overflow, drop; dout=0, dout_valid=0, fifo_level=0.
REQ-028 Reset mid-frame SHALL discard the partial frame; first accepted sample after release starts a new frame.

Structure
REQ-029 Package fir_pkg SHALL hold DIN_W, DOUT_W, SHIFT, FIFO_DEPTH defaults and the accumulator width constant, shared with FIR_filter.
REQ-030 Output buffer SHALL be a separate sub-module fir_sync_fifo (level, full, empty outputs); averaging/requant logic stays in fir_decimator.

Verification
REQ-031 dec_sel=0, din=100 every cycle, dout_ready=1 -> dout=25 every cycle, first dout_valid 2 cycles after first sample edge.
REQ-032 dec_sel=2, din 10,20,30,41 -> single output 6 ((101+8)>>>4); change dec_sel to 3 after 2nd sample -> still one output after 4 samples.
REQ-033 dec_sel=0, din=511 -> dout=127, overflow=1 and stays 1; din=-512 -> dout=-128, no new saturation.
REQ-034 dec_sel=0, dout_ready=0, 6 valid samples 4,8,12,16,20,24 -> fifo_level=4, drop pulses for results 5 and 6; then dout_ready=1 -> 1,2,3,4 in order, fifo_level returns to 0.
REQ-035 dec_sel=3, 5 samples then rst low 1 cycle -> all outputs 0; next 8 samples of 64 -> exactly one output 16.
REQ-036 din_valid toggled 1/0, dec_sel=1, din 40,-40,80,80 -> outputs 0 then 20; invalid cycles ignored.
